serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; the single clock domain.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  minuend; captured on the accepting edge.
REQ-006 Port: B  input  WIDTH  subtrahend; captured on the accepting edge.
REQ-007 Port: Bin  input  1  borrow-in; captured on the accepting edge.
REQ-008 Port: Diff  output  WIDTH  result, A - B - Bin modulo 2^WIDTH.
REQ-009 Port: Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
REQ-010 Port: busy  output  1  high while bit-serial computation is in progress.
REQ-011 Port: done  output  1  single-cycle pulse marking a valid Diff/Bout.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at a rising edge SHALL register A, B, Bin into internal shift/borrow registers, clear the bit counter, and go to SHIFT.
REQ-014 SHIFT SHALL process one bit per cycle, LSB first: d = a XOR b XOR br; br_next = (NOT a AND b) OR (NOT (a XOR b) AND br).
REQ-015 Each SHIFT cycle SHALL shift the operand registers right by one and shift d into the MSB of the result register.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, counted by a counter of ceil(log2(WIDTH+1)) bits, and then go to DONE.
REQ-017 DONE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-018 busy SHALL equal 1 in SHIFT only; done SHALL equal 1 in DONE only. Both are registered outputs.
REQ-019 Latency: with start accepted at edge N, done SHALL be high in the cycle following edge N+WIDTH+1.
REQ-020 Diff and Bout SHALL update on the edge entering DONE and hold until the next result is written. Intermediate bits SHALL never appear on Diff.
REQ-021 start while in SHIFT or DONE SHALL be ignored: no capture, no restart, no queuing.
REQ-022 Changes on A, B or Bin after the accepting edge SHALL have no effect on the current operation.
REQ-023 start held high continuously SHALL start a new operation on every IDLE cycle, which gives back-to-back operations WIDTH+2 cycles apart.
REQ-024 Results SHALL match, bit for bit, the WIDTH+1-bit unsigned subtraction {Bout,Diff} = {1'b0,A} - {1'b0,B} - Bin taken modulo 2^(WIDTH+1).

Reset
REQ-025 rst_n=0 at a rising edge SHALL force: state IDLE, counter 0, internal registers 0, Diff 0, Bout 0, busy 0, done 0.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation with no done pulse, and Diff/Bout SHALL read 0 afterwards.
REQ-027 start sampled in the same cycle as rst_n=0 SHALL be ignored; the first operation is accepted on a later edge with rst_n=1.
REQ-028 No asynchronous reset paths SHALL exist.

Structure
REQ-029 A shared package serial_sub_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and the WIDTH default constant.
REQ-030 The per-bit logic SHALL be a sub-module full_subtractor (inputs a, b, bin; outputs d, bout), purely combinational, instantiated once.
REQ-031 The FSM, counter, shift registers and output registers SHALL reside in serial_subtractor.

Verification
REQ-032 A=0x6A, B=0xDB, Bin=0, start pulse -> done after 9 cycles; Diff=0x8F, Bout=1; busy high for exactly 8 cycles.
REQ-033 A=0xAA, B=0x33, Bin=1 -> Diff=0x76, Bout=0.
REQ-034 Boundary values:
- A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1.
- A=0xFF, B=0xFF, Bin=0 -> Diff=0x00, Bout=0.
REQ-035 Start 0x6A-0xDB, then pulse start with A=0x01, B=0x01 on the 3rd busy cycle -> only one done pulse, Diff=0x8F; next IDLE start is accepted normally.
REQ-036 Drive rst_n=0 on the 4th SHIFT cycle -> no done pulse; busy=0, Diff=0x00, Bout=0 on the next cycle. A fresh 0xAA-0x33-1 then yields Diff=0x76.
REQ-037 Random test: 1000 random A/B/Bin values with start held high -> every done matches the REQ-024 model; done pulses are 10 cycles apart.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when a < b + bin.
// Ports:
//   a, b  - operand bits
//   bin   - borrow in
//   d     - difference bit
//   bout  - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing {Bout,Diff} = A - B - Bin, one bit per
// clock, LSB first, through a single shared full_subtractor.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - request pulse, only honoured in IDLE
//   A, B   - minuend / subtrahend, captured on the accepting edge
//   Bin    - borrow in, captured on the accepting edge
//   Diff   - result, written once per operation on the edge entering DONE
//   Bout   - final borrow, written together with Diff
//   busy   - registered indication that the FSM was in SHIFT
//   done   - registered one-cycle pulse following the DONE state
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Per-bit arithmetic on the current LSBs and running borrow.
    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_nxt)
    );

    // Result register shifts right; the new difference bit enters at the MSB.
    assign res_nxt = (res_sr >> 1) | {d_bit, {(WIDTH-1){1'b0}}};

    // FSM, counter, shift registers and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // Status flags trail the state by one register stage.
            busy <= (state == SHIFT);
            done <= (state == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        br     <= Bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_nxt;
                    res_sr <= res_nxt;
                    cnt    <= cnt + CW'(1);
                    // Last bit: publish the complete result only now.
                    if (cnt == CW'(WIDTH - 1)) begin
                        Diff  <= res_nxt;
                        Bout  <= br_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks for serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_last = 9'h000;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (op_a),
        .B     (op_b),
        .Bin   (op_bin),
        .Diff  (diff),
        .Bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and observe the following W+4 cycles.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic [8:0] prev, output int done_k, output int ndone,
                         output int nbusy, output logic [8:0] res, output bit held);
        op_a = a; op_b = b; op_bin = bin; start = 1'b1;
        tick();
        start  = 1'b0;
        op_a   = 8'($urandom);
        op_b   = 8'($urandom);
        op_bin = 1'($urandom);
        done_k = -1; ndone = 0; nbusy = 0; res = 9'h000; held = 1'b1;
        for (int k = 1; k <= int'(W) + 4; k++) begin
            tick();
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin
                ndone++;
                if (done_k < 0) begin
                    done_k = k;
                    res = {bout, diff};
                end
            end
            if (k < int'(W) && {bout, diff} !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op_a = 8'h55; op_b = 8'h11; op_bin = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, bout, diff} !== 11'h000) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b bout=%b diff=%h want all 0",
                     busy, done, bout, diff);
        end
        rst_n = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored got busy=%b want 0", busy);
        end
        tick();
        checks++;
        if ({busy, done, diff} !== 10'h000) begin
            failures++;
            $display("FAIL reset_idle got busy=%b done=%b diff=%h want 0", busy, done, diff);
        end
        exp_last = 9'h000;
    endtask

    task automatic test_latency();
        int dk, nd, nb;
        logic [8:0] r;
        bit held;
        do_op(8'h6A, 8'hDB, 1'b0, exp_last, dk, nd, nb, r, held);
        checks++;
        if (dk != int'(W) + 1) begin
            failures++;
            $display("FAIL latency got done at %0d want %0d", dk, W + 1);
        end
        checks++;
        if (nd != 1) begin
            failures++;
            $display("FAIL done_pulses got %0d want 1", nd);
        end
        checks++;
        if (nb != int'(W)) begin
            failures++;
            $display("FAIL busy_cycles got %0d want %0d", nb, W);
        end
        checks++;
        if (r !== 9'h18F) begin
            failures++;
            $display("FAIL result_6A_DB got %h want 18f", r);
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL diff_hold got early change want held %h", exp_last);
        end
        exp_last = 9'h18F;
    endtask

    task automatic test_vectors();
        logic [7:0] va [6] = '{8'hAA, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h10};
        logic [7:0] vb [6] = '{8'h33, 8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h01};
        logic       vc [6] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0};
        logic [8:0] ve [6] = '{9'h076, 9'h1FF, 9'h000, 9'h100, 9'h001, 9'h00F};
        int dk, nd, nb;
        logic [8:0] r;
        bit held;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vc[i], exp_last, dk, nd, nb, r, held);
            checks++;
            if (r !== ve[i] || nd != 1 || !held) begin
                failures++;
                $display("FAIL vector_%0d got res=%h pulses=%0d held=%0d want res=%h pulses=1 held=1",
                         i, r, nd, held, ve[i]);
            end
            exp_last = ve[i];
        end
    endtask

    task automatic test_start_ignored();
        int nd = 0;
        int dk = -1;
        logic [8:0] r = 9'h000;
        bit held;
        int nb;
        op_a = 8'h6A; op_b = 8'hDB; op_bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 2 * int'(W) + 6; k++) begin
            tick();
            if (k == 3) begin
                start = 1'b1; op_a = 8'h01; op_b = 8'h01;
            end else if (k == 4) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                nd++;
                if (dk < 0) begin
                    dk = k;
                    r = {bout, diff};
                end
            end
        end
        checks++;
        if (nd != 1 || dk != int'(W) + 1 || r !== 9'h18F) begin
            failures++;
            $display("FAIL start_in_shift got pulses=%0d at=%0d res=%h want pulses=1 at=%0d res=18f",
                     nd, dk, r, W + 1);
        end
        exp_last = 9'h18F;
        do_op(8'h01, 8'h01, 1'b0, exp_last, dk, nd, nb, r, held);
        checks++;
        if (r !== 9'h000 || nd != 1 || dk != int'(W) + 1) begin
            failures++;
            $display("FAIL start_after_idle got res=%h pulses=%0d at=%0d want res=000 pulses=1 at=%0d",
                     r, nd, dk, W + 1);
        end
        exp_last = 9'h000;
    endtask

    task automatic test_reset_abort();
        int dk, nd, nb;
        logic [8:0] r;
        bit held;
        bit seen_done = 1'b0;
        do_op(8'hFF, 8'h01, 1'b0, exp_last, dk, nd, nb, r, held);
        checks++;
        if (r !== 9'h0FE) begin
            failures++;
            $display("FAIL pre_abort got %h want 0fe", r);
        end
        op_a = 8'h6A; op_b = 8'hDB; op_bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, bout, diff} !== 11'h000) begin
            failures++;
            $display("FAIL abort_outputs got busy=%b done=%b bout=%b diff=%h want all 0",
                     busy, done, bout, diff);
        end
        for (int k = 0; k < int'(W) + 4; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("FAIL abort_no_done got activity=1 want 0");
        end
        do_op(8'hAA, 8'h33, 1'b1, 9'h000, dk, nd, nb, r, held);
        checks++;
        if (r !== 9'h076 || nd != 1 || !held) begin
            failures++;
            $display("FAIL after_abort got res=%h pulses=%0d held=%0d want res=076 pulses=1 held=1",
                     r, nd, held);
        end
        exp_last = 9'h076;
    endtask

    // start held high: accepts every W+2 cycles; inputs are junk between accepts.
    task automatic test_back_to_back();
        localparam int NOPS = 1000;
        localparam int P    = int'(W) + 2;
        logic [8:0] q [$];
        logic [8:0] got;
        logic [8:0] want;
        logic       exp_done;
        int         nprint = 0;
        for (int c = 0; c < NOPS * P + 6; c++) begin
            start  = (c < NOPS * P);
            op_a   = 8'($urandom);
            op_b   = 8'($urandom);
            op_bin = 1'($urandom);
            if (c < NOPS * P && (c % P) == 0)
                q.push_back({1'b0, op_a} - {1'b0, op_b} - {8'h00, op_bin});
            tick();
            exp_done = (c < NOPS * P) && ((c % P) == P - 1);
            checks++;
            if (done !== exp_done) begin
                failures++;
                if (nprint < 10) begin
                    nprint++;
                    $display("FAIL b2b_done cycle=%0d got %b want %b", c, done, exp_done);
                end
            end
            if (exp_done && q.size() > 0) begin
                want = q.pop_front();
                got  = {bout, diff};
                checks++;
                if (got !== want) begin
                    failures++;
                    if (nprint < 10) begin
                        nprint++;
                        $display("FAIL b2b_result cycle=%0d got %h want %h", c, got, want);
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; op_bin = 1'b0;
        test_reset();
        test_latency();
        test_vectors();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
